iterative_divider: RTL and testbench

- Unsigned width_p-bit sequential divider: restoring radix-2, one quotient bit per cycle.
- Inverse companion to the chip's combinational multiplier; sits on the same datapath.
- Operands enter through a valid/ready handshake; results leave through a valid/yumi handshake.
- Divide-by-zero short-circuits in one cycle.

---
 rtl/iterative_divider.sv | 143 ++++++++++++++
 tb/tb_iterative_divider.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Unsigned restoring radix-2 sequential divider: one quotient bit per cycle,
// valid/ready operand handshake, valid/yumi result handshake, one-cycle divide-by-zero.
module iterative_divider #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] dividend_i,
    input  logic [width_p-1:0] divisor_i,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] quotient_o,
    output logic [width_p-1:0] remainder_o,
    output logic               div_by_zero_o
);

    localparam int cnt_w_lp = (width_p > 2) ? $clog2(width_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_p - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic [width_p-1:0]    rem_q, rem_d;
    logic [width_p-1:0]    dvd_q, dvd_d;
    logic [width_p-1:0]    dvs_q, dvs_d;
    logic [width_p-1:0]    quot_q, quot_d;
    logic [width_p-1:0]    remo_q, remo_d;
    logic                  dbz_q, dbz_d;
    logic                  v_q, v_d;
    logic                  ready_q, ready_d;

    logic [width_p:0]      shifted;
    logic [width_p:0]      trial;
    logic                  qbit;
    logic [width_p-1:0]    next_rem;
    logic [width_p-1:0]    next_dvd;

    // Since rem < divisor, shifted < 2*divisor, so the MSB of the
    // width_p+1-bit difference is a reliable borrow flag.
    assign shifted  = {rem_q, dvd_q[width_p-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign qbit     = ~trial[width_p];
    assign next_rem = qbit ? trial[width_p-1:0] : shifted[width_p-1:0];
    assign next_dvd = {dvd_q[width_p-2:0], qbit};

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (v_i) begin
                    if (divisor_i != {width_p{1'b0}}) begin
                        dvd_d   = dividend_i;
                        dvs_d   = divisor_i;
                        rem_d   = {width_p{1'b0}};
                        cnt_d   = {cnt_w_lp{1'b0}};
                        state_d = BUSY;
                    end else begin
                        quot_d  = {width_p{1'b1}};
                        remo_d  = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                rem_d = next_rem;
                dvd_d = next_dvd;
                cnt_d = cnt_q + cnt_w_lp'(1);
                if (cnt_q == last_cnt_lp) begin
                    quot_d  = next_dvd;
                    remo_d  = next_rem;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        v_d     = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= {cnt_w_lp{1'b0}};
            rem_q   <= {width_p{1'b0}};
            dvd_q   <= {width_p{1'b0}};
            dvs_q   <= {width_p{1'b0}};
            quot_q  <= {width_p{1'b0}};
            remo_q  <= {width_p{1'b0}};
            dbz_q   <= 1'b0;
            v_q     <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            v_q     <= v_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o       = ready_q;
    assign v_o           = v_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = remo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (width_p=32): directed scenarios plus
// randomized traffic scored against plain-arithmetic division and a multiply-back check.
module tb_iterative_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic         ready_o;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         v_o;
    logic         yumi_i;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_by_zero_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    iterative_divider #(.width_p(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .v_o          (v_o),
        .yumi_i       (yumi_i),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o)
    );

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Present operands for one cycle, scramble inputs while waiting, return cycles to v_o.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        dividend_i = a;
        divisor_i  = b;
        v_i        = 1'b1;
        lat        = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            v_i        = 1'($urandom_range(0, 1));
            dividend_i = $urandom;
            divisor_i  = $urandom;
        end while (v_o !== 1'b1 && lat < 100);
        v_i = 1'b0;
    endtask

    task automatic consume();
        yumi_i = 1'b1;
        @(posedge clk); #1;
        yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
        dividend_i = 32'd0; divisor_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({v_o, ready_o, div_by_zero_o} !== 3'b000) $display("FAIL reset_flags: got v/rdy/dbz=%b required 000", {v_o, ready_o, div_by_zero_o});
        else n_pass++;
        n_total++;
        if ({quotient_o, remainder_o} !== 64'd0) $display("FAIL reset_data: got q=%h r=%h required 0/0", quotient_o, remainder_o);
        else n_pass++;
        reset_i = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({ready_o, v_o} !== 2'b10) $display("FAIL reset_release: got rdy/v=%b required 10", {ready_o, v_o});
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        run_op(32'd100, 32'd7, lat);
        n_total++;
        if (lat !== 33) $display("FAIL basic_latency: got %0d required 33", lat);
        else n_pass++;
        n_total++;
        if ({quotient_o, remainder_o, div_by_zero_o} !== {32'd14, 32'd2, 1'b0})
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b required 14/2/0", quotient_o, remainder_o, div_by_zero_o);
        else n_pass++;
        consume();
        n_total++;
        if ({ready_o, v_o} !== 2'b10) $display("FAIL basic_yumi: got rdy/v=%b required 10", {ready_o, v_o});
        else n_pass++;
    endtask

    task automatic test_boundaries();
        logic [W-1:0] a_tab [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h8000_0000, 32'hFFFF_FFFE};
        logic [W-1:0] b_tab [6] = '{32'd1, 32'hFFFF_FFFF, 32'd10, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat;
        for (int i = 0; i < 6; i++) begin
            ref_div(a_tab[i], b_tab[i], eq, er, ez);
            run_op(a_tab[i], b_tab[i], lat);
            n_total++;
            if (lat !== 33) $display("FAIL bound_latency[%0d]: got %0d required 33", i, lat);
            else n_pass++;
            n_total++;
            if ({quotient_o, remainder_o, div_by_zero_o} !== {eq, er, ez})
                $display("FAIL bound_result[%0d]: got q=%h r=%h dbz=%b required %h/%h/%b", i, quotient_o, remainder_o, div_by_zero_o, eq, er, ez);
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(32'd5, 32'd0, lat);
        n_total++;
        if (lat !== 1) $display("FAIL dbz_latency: got %0d required 1", lat);
        else n_pass++;
        n_total++;
        if ({quotient_o, remainder_o, div_by_zero_o} !== {32'hFFFF_FFFF, 32'd5, 1'b1})
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b required ffffffff/5/1", quotient_o, remainder_o, div_by_zero_o);
        else n_pass++;
        consume();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat;
        ref_div(32'd123456789, 32'd1000, eq, er, ez);
        run_op(32'd123456789, 32'd1000, lat);
        for (int i = 0; i < 10; i++) begin
            v_i        = ~v_i;
            dividend_i = $urandom;
            divisor_i  = (i % 3 == 0) ? 32'd0 : $urandom;
            @(posedge clk); #1;
            n_total++;
            if ({v_o, ready_o, quotient_o, remainder_o, div_by_zero_o} !== {1'b1, 1'b0, eq, er, ez})
                $display("FAIL hold[%0d]: got v=%b rdy=%b q=%h r=%h required 1/0/%h/%h", i, v_o, ready_o, quotient_o, remainder_o, eq, er);
            else n_pass++;
        end
        v_i = 1'b0;
        consume();
        yumi_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if ({v_o, ready_o} !== 2'b01) $display("FAIL idle_yumi[%0d]: got v/rdy=%b required 01", i, {v_o, ready_o});
            else n_pass++;
        end
        yumi_i = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        bit saw_v = 1'b0;
        int lat;
        dividend_i = 32'hDEAD_BEEF;
        divisor_i  = 32'd3;
        v_i        = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset_i = 1'b1;
        #1;
        n_total++;
        if ({v_o, ready_o, quotient_o, remainder_o, div_by_zero_o} !== 67'd0)
            $display("FAIL async_reset: got v=%b rdy=%b q=%h r=%h dbz=%b required all 0", v_o, ready_o, quotient_o, remainder_o, div_by_zero_o);
        else n_pass++;
        @(posedge clk); #1;
        reset_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (v_o === 1'b1) saw_v = 1'b1;
        end
        n_total++;
        if ({saw_v, ready_o} !== 2'b01) $display("FAIL abort: got saw_v/rdy=%b required 01", {saw_v, ready_o});
        else n_pass++;
        run_op(32'd1000, 32'd33, lat);
        n_total++;
        if (lat !== 33) $display("FAIL post_reset_latency: got %0d required 33", lat);
        else n_pass++;
        n_total++;
        if ({quotient_o, remainder_o, div_by_zero_o} !== {32'd30, 32'd10, 1'b0})
            $display("FAIL post_reset_result: got q=%0d r=%0d dbz=%b required 30/10/0", quotient_o, remainder_o, div_by_zero_o);
        else n_pass++;
        consume();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic         ez;
        logic [63:0]  prod;
        int           lat, sel;
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 99);
            a   = (sel % 5 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            if (sel < 5)       b = 32'd0;
            else if (sel < 40) b = 32'($urandom_range(1, 255));
            else               b = $urandom;
            if (b == 32'd0 && sel >= 5) b = 32'd1;
            ref_div(a, b, eq, er, ez);
            run_op(a, b, lat);
            n_total++;
            if (lat !== (ez ? 1 : 33)) $display("FAIL rnd_latency[%0d]: got %0d required %0d", i, lat, ez ? 1 : 33);
            else n_pass++;
            n_total++;
            if ({quotient_o, remainder_o, div_by_zero_o} !== {eq, er, ez})
                $display("FAIL rnd_result[%0d] %h/%h: got q=%h r=%h dbz=%b required %h/%h/%b", i, a, b, quotient_o, remainder_o, div_by_zero_o, eq, er, ez);
            else n_pass++;
            if (!ez) begin
                prod = 64'(quotient_o) * 64'(b) + 64'(remainder_o);
                n_total++;
                if (prod !== 64'(a) || remainder_o >= b)
                    $display("FAIL rnd_invariant[%0d]: got q*d+r=%h r=%h required %h and r<%h", i, prod, remainder_o, a, b);
                else n_pass++;
            end
            repeat ($urandom_range(0, 5)) begin
                @(posedge clk); #1;
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
